velocity_ramp: RTL and testbench
================================

// Module: velocity_ramp
// PURPOSE
//  Control-unit stage directly downstream of the update-tick generator. Each update pulse:
//  - commits double-buffered setpoints;
//  - advances a slew-limited velocity toward a clamped target;
//  - integrates velocity into position;
//  - strobes the new (pos, vel) sample to the following loop/step stages.
//  The computation is sequenced over 3 cycles by a small FSM. Overrun is flagged when ticks arrive too fast.
// PARAMETERS
//  VW  32  velocity width, signed two's complement
//  PW  48  position width, signed; wraps modulo 2^PW
// PORTS
//  clk         in   1      clock
//  N_reset     in   1      reset, asynchronous, active-low
//  update      in   1      1-cycle tick from update generator
//  enable      in   1      1: ramp toward v_target; 0: ramp toward 0 (controlled stop)
//  wr_en       in   1      write shadow setpoint registers this cycle
//  v_target    in   VW     signed target velocity (shadow)
//  v_max       in   VW-1   unsigned velocity magnitude limit (shadow)
//  a_max       in   VW-1   unsigned max |dv| per tick (shadow)
//  pos_clear   in   1      synchronous position clear
//  ovr_clear   in   1      clear sticky overrun flag
//  pos         out  PW     signed position
//  vel         out  VW     signed velocity
//  sample_vld  out  1      1-cycle strobe: pos/vel updated for this tick
//  busy        out  1      FSM not IDLE
//  overrun     out  1      sticky: update seen while busy
// BEHAVIOUR
//  Reset values:
//  - pos, vel, sample_vld, overrun = 0; busy = 0; state = IDLE.
//  - Shadow and active setpoint registers = 0.
//  FSM: IDLE -> APPLY -> VEL -> POS -> IDLE.
//  - IDLE:  update=1 -> APPLY; otherwise hold.
//  - APPLY: active <= shadow (v_target, v_max, a_max), enable sampled into active.
//  - VEL:   vt = en ? clamp(v_target, -v_max, +v_max) : 0; d = vt - vel.
//           d > a_max -> vel += a_max; d < -a_max -> vel -= a_max; else vel = vt.
//           Arithmetic is done in VW+2 bits so no intermediate overflow occurs; the result always fits in VW.
//  - POS:   pos <= pos + sign_extend(vel_new); wraps modulo 2^PW.
//           sample_vld=1 in the cycle after POS, i.e. 4 cycles after the update cycle.
//  Latency / period:
//  - update at cycle N gives new vel at N+3 and sample_vld at N+4.
//  - Minimum tick period is 4 cycles (t_up >= 3).
//  busy = (state != IDLE), combinational from the state register.
//  Boundary rules:
//  - update while busy: ignored (no restart); overrun <= 1.
//  - ovr_clear with a simultaneous overrun event: set wins.
//  - wr_en in the APPLY cycle: APPLY copies the old shadow; the new value takes effect on the next tick.
//  - wr_en in any other cycle: the shadow updates next edge.
//  - pos_clear: pos <= 0 next edge in any state. It beats the POS-state add; vel is unaffected.
//  - a_max = 0: vel frozen unless already equal to vt.
//  - v_max = 0: vt = 0.
//  - vel beyond a newly reduced v_max: ramps down at a_max/tick; no jump.
//  - enable deasserted mid-sequence: has no effect until the next APPLY.
//  - Asynchronous reset mid-sequence: all state returns to reset values immediately; no sample_vld is emitted.
// STRUCTURE
//  - Package ctrl_pkg: state_t enum {IDLE, APPLY, VEL, POS}; default VW/PW localparams; sat/clamp helper function.
//  - Sub-module slew_limiter: combinational (vel, vt, a_max) -> vel_next, VW-parameterised. Used in the VEL state.
//  - The remaining logic (FSM, shadow/active registers, integrator, flags) stays in velocity_ramp.
// TESTING
//  1. Reset, write v_target=100, v_max=1000, a_max=30, enable=1, tick every 10 cycles:
//     vel = 30, 60, 90, 100, 100; pos = 30, 90, 180, 280, 380; sample_vld 4 cycles after each tick.
//  2. v_target=-5000, v_max=1000, a_max=400, starting from vel=0:
//     vel = -400, -800, -1000, -1000 (clamped).
//  3. Ticks 2 cycles apart: second tick ignored, overrun=1 and stays set. ovr_clear -> 0.
//     ovr_clear together with a new overrun -> remains 1.
//  4. vel=100, enable 0 before a tick, a_max=30: vel = 70, 40, 10, 0, 0.
//  5. PW=8, pos=120, vel=10: after a tick pos=-126 (wrap).
//     pos_clear asserted in the POS cycle: pos=0.
//  6. wr_en v_target=50 in the APPLY cycle of a tick with the old target 0:
//     vel stays 0 this tick; next tick vel=min(50, a_max).
//     Reset asserted in the VEL cycle: all outputs 0, no sample_vld.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and helpers for the velocity ramp control stage.
package ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    VEL   = 2'd2,
    POS   = 2'd3
  } state_t;

  localparam int VW_DEF = 32;
  localparam int PW_DEF = 48;

  // Wide enough to hold any VW+2 intermediate for the widths used here.
  localparam int CW = 64;
  typedef logic signed [CW-1:0] wide_t;

  // Symmetric saturation of x into [-lim, +lim]; lim must be non-negative.
  function automatic wide_t clamp_sym(input wide_t x, input wide_t lim);
    wide_t r;
    if (x > lim) begin
      r = lim;
    end else if (x < -lim) begin
      r = -lim;
    end else begin
      r = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/slew_limiter.sv
// Moves vel toward vt by at most a_max per evaluation.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module slew_limiter #(
  parameter int VW = 32
) (
  input  logic [VW-1:0] vel,
  input  logic [VW-1:0] vt,
  input  logic [VW-2:0] a_max,
  output logic [VW-1:0] vel_next
);

  localparam int XW = VW + 2;

  logic signed [XW-1:0] vel_x;
  logic signed [XW-1:0] vt_x;
  logic signed [XW-1:0] amax_x;
  logic signed [XW-1:0] d_x;

  // Two guard bits keep vt - vel and vel +/- a_max free of overflow.
  assign vel_x  = {{2{vel[VW-1]}}, vel};
  assign vt_x   = {{2{vt[VW-1]}}, vt};
  assign amax_x = {3'b000, a_max};
  assign d_x    = vt_x - vel_x;

  always_comb begin
    vel_next = vt;
    if (d_x > amax_x) begin
      vel_next = VW'(vel_x + amax_x);
    end else if (d_x < -amax_x) begin
      vel_next = VW'(vel_x - amax_x);
    end
  end

endmodule

// File: rtl/velocity_ramp.sv
// Per-tick setpoint commit, slew-limited velocity and position integration.
// Latency: update at N -> vel at N+3, pos and sample_vld at N+4; 4-cycle min period.
// Backpressure: none; ticks arriving while busy are dropped and flag overrun.
module velocity_ramp
  import ctrl_pkg::*;
#(
  parameter int VW = VW_DEF,
  parameter int PW = PW_DEF
) (
  input  logic          clk,
  input  logic          N_reset,
  input  logic          update,
  input  logic          enable,
  input  logic          wr_en,
  input  logic [VW-1:0] v_target,
  input  logic [VW-2:0] v_max,
  input  logic [VW-2:0] a_max,
  input  logic          pos_clear,
  input  logic          ovr_clear,
  output logic [PW-1:0] pos,
  output logic [VW-1:0] vel,
  output logic          sample_vld,
  output logic          busy,
  output logic          overrun
);

  state_t state;
  state_t state_nxt;

  logic ld_act;
  logic ld_vel;
  logic ld_pos;

  logic signed [VW-1:0] sh_vt;
  logic        [VW-2:0] sh_vmax;
  logic        [VW-2:0] sh_amax;

  logic signed [VW-1:0] act_vt;
  logic        [VW-2:0] act_vmax;
  logic        [VW-2:0] act_amax;
  logic                 act_en;

  logic signed [VW-1:0] vel_r;
  logic signed [VW-1:0] vt;
  logic        [VW-1:0] vel_next;
  logic signed [PW-1:0] pos_r;

  always_ff @(posedge clk or negedge N_reset) begin
    if (!N_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (update) state_nxt = APPLY;
      APPLY:   state_nxt = VEL;
      VEL:     state_nxt = POS;
      POS:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ld_act = (state == APPLY);
    ld_vel = (state == VEL);
    ld_pos = (state == POS);
    busy   = (state != IDLE);
  end

  // Shadow is always writable; APPLY samples it before a same-cycle write lands.
  always_ff @(posedge clk or negedge N_reset) begin
    if (!N_reset) begin
      sh_vt   <= '0;
      sh_vmax <= '0;
      sh_amax <= '0;
    end else if (wr_en) begin
      sh_vt   <= v_target;
      sh_vmax <= v_max;
      sh_amax <= a_max;
    end
  end

  always_ff @(posedge clk or negedge N_reset) begin
    if (!N_reset) begin
      act_vt   <= '0;
      act_vmax <= '0;
      act_amax <= '0;
      act_en   <= 1'b0;
    end else if (ld_act) begin
      act_vt   <= sh_vt;
      act_vmax <= sh_vmax;
      act_amax <= sh_amax;
      act_en   <= enable;
    end
  end

  assign vt = act_en ? VW'(clamp_sym(wide_t'(act_vt), wide_t'(act_vmax))) : '0;

  slew_limiter #(
    .VW(VW)
  ) u_slew (
    .vel      (vel_r),
    .vt       (vt),
    .a_max    (act_amax),
    .vel_next (vel_next)
  );

  always_ff @(posedge clk or negedge N_reset) begin
    if (!N_reset) begin
      vel_r <= '0;
    end else if (ld_vel) begin
      vel_r <= vel_next;
    end
  end

  // The size cast sign-extends (or truncates) vel into the position width.
  always_ff @(posedge clk or negedge N_reset) begin
    if (!N_reset) begin
      pos_r <= '0;
    end else if (pos_clear) begin
      pos_r <= '0;
    end else if (ld_pos) begin
      pos_r <= pos_r + PW'(vel_r);
    end
  end

  always_ff @(posedge clk or negedge N_reset) begin
    if (!N_reset) begin
      sample_vld <= 1'b0;
    end else begin
      sample_vld <= ld_pos;
    end
  end

  // A fresh overrun event takes priority over a simultaneous clear.
  always_ff @(posedge clk or negedge N_reset) begin
    if (!N_reset) begin
      overrun <= 1'b0;
    end else if (update && busy) begin
      overrun <= 1'b1;
    end else if (ovr_clear) begin
      overrun <= 1'b0;
    end
  end

  assign pos = pos_r;
  assign vel = vel_r;

endmodule

// File: tb/tb_velocity_ramp.sv
// Directed self-checking bench for velocity_ramp; a second instance with PW=8 covers position wrap.
module tb_velocity_ramp;

  logic        clk = 1'b0;
  logic        N_reset = 1'b0;
  logic        update = 1'b0;
  logic        enable = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] v_target = '0;
  logic [30:0] v_max = '0;
  logic [30:0] a_max = '0;
  logic        pos_clear = 1'b0;
  logic        ovr_clear = 1'b0;

  logic [47:0] pos;
  logic [31:0] vel;
  logic        sample_vld;
  logic        busy;
  logic        overrun;

  logic [7:0]  pos8;
  logic [31:0] vel8;
  logic        sample_vld8;
  logic        busy8;
  logic        overrun8;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  velocity_ramp #(.VW(32), .PW(48)) dut (
    .clk(clk), .N_reset(N_reset), .update(update), .enable(enable), .wr_en(wr_en),
    .v_target(v_target), .v_max(v_max), .a_max(a_max), .pos_clear(pos_clear),
    .ovr_clear(ovr_clear), .pos(pos), .vel(vel), .sample_vld(sample_vld),
    .busy(busy), .overrun(overrun)
  );

  velocity_ramp #(.VW(32), .PW(8)) dut8 (
    .clk(clk), .N_reset(N_reset), .update(update), .enable(enable), .wr_en(wr_en),
    .v_target(v_target), .v_max(v_max), .a_max(a_max), .pos_clear(pos_clear),
    .ovr_clear(ovr_clear), .pos(pos8), .vel(vel8), .sample_vld(sample_vld8),
    .busy(busy8), .overrun(overrun8)
  );

  task automatic do_reset();
    N_reset = 1'b0;
    update = 1'b0;
    wr_en = 1'b0;
    pos_clear = 1'b0;
    ovr_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1 N_reset = 1'b1;
  endtask

  task automatic write_sp(input logic [31:0] t, input logic [30:0] vm, input logic [30:0] am);
    @(posedge clk);
    #1 wr_en = 1'b1; v_target = t; v_max = vm; a_max = am;
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  // One tick; returns vel/pos at the strobe and whether sample_vld fired exactly at N+4.
  task automatic run_tick(output logic [31:0] v, output logic [47:0] p, output logic sv_ok);
    sv_ok = 1'b1;
    @(posedge clk);
    #1 update = 1'b1;
    @(posedge clk);
    #1 update = 1'b0;
    if (sample_vld || sample_vld8) sv_ok = 1'b0;
    @(posedge clk); #1;
    if (sample_vld || sample_vld8) sv_ok = 1'b0;
    @(posedge clk); #1;
    if (sample_vld || sample_vld8) sv_ok = 1'b0;
    @(posedge clk); #1;
    if (!sample_vld || !sample_vld8) sv_ok = 1'b0;
    v = vel;
    p = pos;
    @(posedge clk); #1;
    if (sample_vld || sample_vld8) sv_ok = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (pos !== 48'd0) begin n_fail++; $display("FAIL reset_pos: got %0d want 0", pos); end
    n_checks++; if (vel !== 32'd0) begin n_fail++; $display("FAIL reset_vel: got %0d want 0", vel); end
    n_checks++; if (sample_vld !== 1'b0) begin n_fail++; $display("FAIL reset_sample_vld: got %b want 0", sample_vld); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    n_checks++; if (pos8 !== 8'd0) begin n_fail++; $display("FAIL reset_pos8: got %0d want 0", pos8); end
  endtask

  task automatic test_ramp_up();
    logic signed [31:0] exp_v [5] = '{30, 60, 90, 100, 100};
    logic signed [47:0] exp_p [5] = '{30, 90, 180, 280, 380};
    logic [31:0] v;
    logic [47:0] p;
    logic ok;
    enable = 1'b1;
    write_sp(32'd100, 31'd1000, 31'd30);
    for (int i = 0; i < 5; i++) begin
      run_tick(v, p, ok);
      n_checks++; if (v !== exp_v[i]) begin n_fail++; $display("FAIL ramp_vel[%0d]: got %0d want %0d", i, $signed(v), exp_v[i]); end
      n_checks++; if (p !== exp_p[i]) begin n_fail++; $display("FAIL ramp_pos[%0d]: got %0d want %0d", i, $signed(p), exp_p[i]); end
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL ramp_strobe[%0d]: got %b want 1", i, ok); end
      repeat (5) @(posedge clk);
    end
  endtask

  task automatic test_clamp_neg();
    logic signed [31:0] exp_v [4] = '{-400, -800, -1000, -1000};
    logic [31:0] v;
    logic [47:0] p;
    logic ok;
    do_reset();
    write_sp(-32'sd5000, 31'd1000, 31'd400);
    for (int i = 0; i < 4; i++) begin
      run_tick(v, p, ok);
      n_checks++; if (v !== exp_v[i]) begin n_fail++; $display("FAIL clamp_vel[%0d]: got %0d want %0d", i, $signed(v), exp_v[i]); end
    end
    n_checks++; if (p !== -48'sd3200) begin n_fail++; $display("FAIL clamp_pos: got %0d want -3200", $signed(p)); end
  endtask

  task automatic test_overrun();
    int cnt = 0;
    int first = -1;
    logic busy_apply = 1'b0;
    do_reset();
    write_sp(32'd100, 31'd1000, 31'd30);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (sample_vld) begin cnt++; if (first < 0) first = k; end
      if (k == 1) busy_apply = busy;
      update = (k == 0 || k == 2);
    end
    n_checks++; if (busy_apply !== 1'b1) begin n_fail++; $display("FAIL ovr_busy_apply: got %b want 1", busy_apply); end
    n_checks++; if (cnt != 1) begin n_fail++; $display("FAIL ovr_strobe_count: got %0d want 1", cnt); end
    n_checks++; if (first != 4) begin n_fail++; $display("FAIL ovr_strobe_cycle: got %0d want 4", first); end
    n_checks++; if (vel !== 32'd30) begin n_fail++; $display("FAIL ovr_vel: got %0d want 30", $signed(vel)); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ovr_busy_end: got %b want 0", busy); end
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
    @(posedge clk);
    #1 ovr_clear = 1'b1;
    @(posedge clk);
    #1 ovr_clear = 1'b0;
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", overrun); end
    @(posedge clk);
    #1 update = 1'b1;
    @(posedge clk);
    #1 update = 1'b0;
    @(posedge clk);
    #1 update = 1'b1; ovr_clear = 1'b1;
    @(posedge clk);
    #1 update = 1'b0; ovr_clear = 1'b0;
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set_wins: got %b want 1", overrun); end
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (vel !== 32'd60) begin n_fail++; $display("FAIL ovr_vel2: got %0d want 60", $signed(vel)); end
  endtask

  task automatic test_stop();
    logic signed [31:0] exp_v [5] = '{70, 40, 10, 0, 0};
    logic [31:0] v;
    logic [47:0] p;
    logic ok;
    do_reset();
    enable = 1'b1;
    write_sp(32'd100, 31'd1000, 31'd100);
    run_tick(v, p, ok);
    n_checks++; if (v !== 32'd100) begin n_fail++; $display("FAIL stop_prep_vel: got %0d want 100", $signed(v)); end
    write_sp(32'd100, 31'd1000, 31'd30);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      run_tick(v, p, ok);
      n_checks++; if (v !== exp_v[i]) begin n_fail++; $display("FAIL stop_vel[%0d]: got %0d want %0d", i, $signed(v), exp_v[i]); end
    end
    enable = 1'b1;
  endtask

  task automatic test_wrap();
    logic [31:0] v;
    logic [47:0] p;
    logic ok;
    do_reset();
    enable = 1'b1;
    write_sp(32'd10, 31'd1000, 31'd10);
    repeat (12) run_tick(v, p, ok);
    n_checks++; if (pos8 !== 8'd120) begin n_fail++; $display("FAIL wrap_pre_pos8: got %0d want 120", $signed(pos8)); end
    n_checks++; if (vel8 !== 32'd10) begin n_fail++; $display("FAIL wrap_pre_vel8: got %0d want 10", $signed(vel8)); end
    run_tick(v, p, ok);
    n_checks++; if (pos8 !== 8'h82) begin n_fail++; $display("FAIL wrap_pos8: got %0d want -126", $signed(pos8)); end
    n_checks++; if (p !== 48'd130) begin n_fail++; $display("FAIL wrap_pos48: got %0d want 130", $signed(p)); end
    @(posedge clk);
    #1 update = 1'b1;
    @(posedge clk);
    #1 update = 1'b0;
    @(posedge clk); #1;
    @(posedge clk);
    #1 pos_clear = 1'b1;
    @(posedge clk);
    #1 pos_clear = 1'b0;
    n_checks++; if (pos !== 48'd0) begin n_fail++; $display("FAIL clear_pos48: got %0d want 0", $signed(pos)); end
    n_checks++; if (pos8 !== 8'd0) begin n_fail++; $display("FAIL clear_pos8: got %0d want 0", $signed(pos8)); end
    n_checks++; if (vel !== 32'd10) begin n_fail++; $display("FAIL clear_vel: got %0d want 10", $signed(vel)); end
    n_checks++; if (sample_vld !== 1'b1) begin n_fail++; $display("FAIL clear_strobe: got %b want 1", sample_vld); end
  endtask

  task automatic test_apply_write();
    logic [31:0] v;
    logic [47:0] p;
    logic ok;
    int cnt = 0;
    do_reset();
    enable = 1'b1;
    write_sp(32'd0, 31'd1000, 31'd30);
    @(posedge clk);
    #1 update = 1'b1;
    @(posedge clk);
    #1 update = 1'b0; wr_en = 1'b1; v_target = 32'd50;
    @(posedge clk);
    #1 wr_en = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (vel !== 32'd0) begin n_fail++; $display("FAIL apply_old_vel: got %0d want 0", $signed(vel)); end
    @(posedge clk); #1;
    n_checks++; if (sample_vld !== 1'b1) begin n_fail++; $display("FAIL apply_strobe: got %b want 1", sample_vld); end
    run_tick(v, p, ok);
    n_checks++; if (v !== 32'd30) begin n_fail++; $display("FAIL apply_new_vel: got %0d want 30", $signed(v)); end
    n_checks++; if (p !== 48'd30) begin n_fail++; $display("FAIL apply_new_pos: got %0d want 30", $signed(p)); end
    @(posedge clk);
    #1 update = 1'b1;
    @(posedge clk);
    #1 update = 1'b0;
    @(posedge clk);
    #1 N_reset = 1'b0;
    #1;
    n_checks++; if (vel !== 32'd0) begin n_fail++; $display("FAIL midrst_vel: got %0d want 0", $signed(vel)); end
    n_checks++; if (pos !== 48'd0) begin n_fail++; $display("FAIL midrst_pos: got %0d want 0", $signed(pos)); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_checks++; if (sample_vld !== 1'b0) begin n_fail++; $display("FAIL midrst_strobe: got %b want 0", sample_vld); end
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (k == 2) N_reset = 1'b1;
      if (sample_vld) cnt++;
    end
    n_checks++; if (cnt != 0) begin n_fail++; $display("FAIL midrst_no_strobe: got %0d pulses want 0", cnt); end
    n_checks++; if (vel !== 32'd0) begin n_fail++; $display("FAIL midrst_vel_after: got %0d want 0", $signed(vel)); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ramp_up();
    test_clamp_neg();
    test_overrun();
    test_stop();
    test_wrap();
    test_apply_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
